// File: rtl/piso_tx_arbiter.sv
// Two-requester round-robin front end for a WIDTH-bit PISO shift register.
// Grants one parallel word per frame, pulses load, then flags the WIDTH serial bits.
module piso_tx_arbiter #(
  parameter int WIDTH = 4,
  parameter int GAP   = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic [WIDTH-1:0] data0,
  input  logic             req1,
  input  logic [WIDTH-1:0] data1,
  output logic             gnt0,
  output logic             gnt1,
  output logic [WIDTH-1:0] pi,
  output logic             load,
  output logic             so_valid,
  output logic             owner,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_GAP
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [3:0]         gap_q, gap_d;
  logic               last_owner_q, last_owner_d;
  logic               owner_q, owner_d;
  logic [WIDTH-1:0]   pi_q, pi_d;
  logic               gnt0_q, gnt0_d;
  logic               gnt1_q, gnt1_d;
  logic               winner;

  // On a tie the requester that did not own the previous frame wins.
  assign winner = req1 & (~req0 | ~last_owner_q);

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path leaves it unassigned (no latches).
    state_d      = state_q;
    cnt_d        = cnt_q;
    gap_d        = gap_q;
    last_owner_d = last_owner_q;
    owner_d      = owner_q;
    pi_d         = pi_q;
    gnt0_d       = 1'b0;
    gnt1_d       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req0 || req1) begin
          state_d      = S_LOAD;
          pi_d         = winner ? data1 : data0;
          owner_d      = winner;
          last_owner_d = winner;
          gnt0_d       = ~winner;
          gnt1_d       = winner;
        end
      end

      S_LOAD: begin
        state_d = S_SHIFT;
        cnt_d   = '0;
      end

      S_SHIFT: begin
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          cnt_d   = '0;
          gap_d   = '0;
          state_d = (GAP > 0) ? S_GAP : S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_GAP: begin
        if (gap_q == 4'(GAP - 1)) begin
          gap_d   = '0;
          state_d = S_IDLE;
        end else begin
          gap_d = gap_q + 4'd1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      gap_q        <= '0;
      last_owner_q <= 1'b1;
      owner_q      <= 1'b0;
      pi_q         <= '0;
      gnt0_q       <= 1'b0;
      gnt1_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      gap_q        <= gap_d;
      last_owner_q <= last_owner_d;
      owner_q      <= owner_d;
      pi_q         <= pi_d;
      gnt0_q       <= gnt0_d;
      gnt1_q       <= gnt1_d;
    end
  end

  // Outputs come straight from registers or from decoded state only.
  assign gnt0     = gnt0_q;
  assign gnt1     = gnt1_q;
  assign pi       = pi_q;
  assign owner    = owner_q;
  assign load     = (state_q == S_LOAD);
  assign so_valid = (state_q == S_SHIFT);
  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_SHIFT) && (cnt_q == CNT_W'(WIDTH - 1));

endmodule

// File: tb/tb_piso_tx_arbiter.sv
// Scoreboard bench for piso_tx_arbiter: a grant-schedule model feeds expected frames
// to a monitor that checks grants, timing and the serial stream of an attached PISO model.
module tb_piso_tx_arbiter;

  localparam int WIDTH   = 4;
  localparam int GAP     = 0;
  localparam int GAP_G   = 2;
  localparam int SPACING = WIDTH + 2 + GAP;

  logic             clk = 1'b0;
  logic             reset;
  logic             req0, req1;
  logic [WIDTH-1:0] data0, data1;
  logic             gnt0, gnt1, load, so_valid, owner, busy, done;
  logic [WIDTH-1:0] pi;

  logic             req0_g;
  logic [WIDTH-1:0] data0_g;
  logic             gnt0_g, gnt1_g, load_g, so_valid_g, owner_g, busy_g, done_g;
  logic [WIDTH-1:0] pi_g;

  always #5 clk = ~clk;

  piso_tx_arbiter #(.WIDTH(WIDTH), .GAP(GAP)) u_dut (
    .clk(clk), .reset(reset),
    .req0(req0), .data0(data0), .req1(req1), .data1(data1),
    .gnt0(gnt0), .gnt1(gnt1), .pi(pi), .load(load), .so_valid(so_valid),
    .owner(owner), .busy(busy), .done(done)
  );

  piso_tx_arbiter #(.WIDTH(WIDTH), .GAP(GAP_G)) u_dut_gap (
    .clk(clk), .reset(reset),
    .req0(req0_g), .data0(data0_g), .req1(1'b0), .data1(4'h0),
    .gnt0(gnt0_g), .gnt1(gnt1_g), .pi(pi_g), .load(load_g), .so_valid(so_valid_g),
    .owner(owner_g), .busy(busy_g), .done(done_g)
  );

  // External shift register the controller drives: parallel load, shift right, so = bit 0.
  logic [WIDTH-1:0] sr;
  logic             so;
  always @(posedge clk or negedge reset) begin
    if (!reset)    sr <= '0;
    else if (load) sr <= pi;
    else           sr <= {1'b0, sr[WIDTH-1:1]};
  end
  assign so = sr[0];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic             owner;
    logic [WIDTH-1:0] data;
    int               edge_n;
  } frame_t;

  frame_t exp_q[$];

  // Reference model: a frame occupies SPACING edges; the next request can be taken at
  // the first edge after that, and ties go to whoever did not win last time.
  int   edge_n       = 0;
  int   free_edge    = 0;
  logic m_last_owner = 1'b1;
  logic granted0, granted1;

  task automatic tick();
    logic w;
    @(posedge clk);
    edge_n++;
    granted0 = 1'b0;
    granted1 = 1'b0;
    if (reset && edge_n >= free_edge && (req0 || req1)) begin
      w = (req0 && req1) ? ~m_last_owner : req1;
      exp_q.push_back('{w, w ? data1 : data0, edge_n});
      m_last_owner = w;
      free_edge    = edge_n + SPACING;
      if (w) granted1 = 1'b1;
      else   granted0 = 1'b1;
    end
    #1;
  endtask

  task automatic wait_idle();
    req0 = 1'b0;
    req1 = 1'b0;
    while (edge_n < free_edge + 1) tick();
  endtask

  // Monitor for the GAP=0 instance.
  frame_t           cur;
  bit               active = 1'b0;
  int               since  = 0;
  int               nb     = 0;
  logic [WIDTH-1:0] bits;

  always @(negedge clk) begin
    if (!reset) begin
      active = 1'b0;
    end else begin
      check("gnt_exclusive", 32'(gnt0 & gnt1), 0);
      check("load_vs_so_valid", 32'(load & so_valid), 0);
      if (gnt0 || gnt1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_grant", 1, 0);
          active = 1'b0;
        end else begin
          cur = exp_q.pop_front();
          check("grant_id", 32'(gnt1), 32'(cur.owner));
          check("grant_edge", edge_n, cur.edge_n);
          check("owner", 32'(owner), 32'(cur.owner));
          check("pi", 32'(pi), 32'(cur.data));
          check("load_cycle1", 32'(load), 1);
          check("busy_cycle1", 32'(busy), 1);
          active = 1'b1;
          since  = 1;
          nb     = 0;
          bits   = '0;
        end
      end else if (active) begin
        since++;
        check("so_valid_window", 32'(so_valid), 32'(since >= 2 && since <= WIDTH + 1));
        check("done_cycle", 32'(done), 32'(since == WIDTH + 1));
        check("busy_frame", 32'(busy), 32'(since <= WIDTH + 1 + GAP));
        if (so_valid && nb < WIDTH) begin
          bits[nb] = so;
          nb++;
        end
        if (since == WIDTH + 1) begin
          check("serial_word", 32'(bits), 32'(cur.data));
          check("done_owner", 32'(owner), 32'(cur.owner));
        end
        if (since >= WIDTH + 2 + GAP) active = 1'b0;
      end else begin
        check("idle_quiet", 32'({load, so_valid, done, busy}), 0);
      end
    end
  end

  // Monitor for the GAP=2 instance, whose req0 is held high the whole run.
  int cyc_g  = 0;
  int last_g = 0;
  int rel;
  bit have_g = 1'b0;

  always @(negedge clk) begin
    cyc_g++;
    if (!reset) begin
      have_g = 1'b0;
    end else begin
      check("g_no_gnt1", 32'(gnt1_g), 0);
      if (gnt0_g) begin
        if (have_g) check("g_spacing", cyc_g - last_g, 8);
        have_g = 1'b1;
        last_g = cyc_g;
      end else if (have_g) begin
        rel = cyc_g - last_g;
        if (rel >= 1 && rel <= 4) check("g_so_valid", 32'(so_valid_g), 1);
        if (rel == 5 || rel == 6) begin
          check("g_gap_busy", 32'(busy_g), 1);
          check("g_gap_so_valid", 32'(so_valid_g), 0);
        end
        if (rel == 7) check("g_idle_busy", 32'(busy_g), 0);
      end
    end
  end

  initial begin
    reset   = 1'b0;
    req0    = 1'b0;
    req1    = 1'b0;
    data0   = '0;
    data1   = '0;
    req0_g  = 1'b1;
    data0_g = 4'h6;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", 32'({pi, gnt0, gnt1, load, so_valid, owner, busy, done}), 0);
    check("reset_outputs_gap", 32'({pi_g, gnt0_g, load_g, so_valid_g, busy_g, done_g}), 0);
    reset = 1'b1;

    // Single word 1011 from requester 0.
    req0  = 1'b1;
    data0 = 4'b1011;
    tick();
    req0 = 1'b0;
    wait_idle();

    // Both held: alternating owners.
    req0  = 1'b1; data0 = 4'h3;
    req1  = 1'b1; data1 = 4'hC;
    repeat (4 * SPACING) tick();
    wait_idle();

    // Requester 1 alone.
    req1  = 1'b1; data1 = 4'h5;
    repeat (3 * SPACING) tick();
    wait_idle();

    // Requester 1 pulses during SHIFT and drops: must not be served.
    req0  = 1'b1; data0 = 4'h9;
    tick();
    req0 = 1'b0;
    tick();
    req1 = 1'b1; data1 = 4'hF;
    tick();
    tick();
    req1 = 1'b0;
    repeat (10) tick();

    // Randomized traffic.
    for (int i = 0; i < 2000; i++) begin
      if (req0 && !granted0) begin
        if ($urandom_range(0, 15) == 0) req0 = 1'b0;
      end else begin
        req0  = ($urandom_range(0, 2) == 0);
        data0 = WIDTH'($urandom);
      end
      if (req1 && !granted1) begin
        if ($urandom_range(0, 15) == 0) req1 = 1'b0;
      end else begin
        req1  = ($urandom_range(0, 2) == 0);
        data1 = WIDTH'($urandom);
      end
      tick();
    end
    wait_idle();

    // Reset on the 3rd SHIFT cycle aborts the frame.
    req0 = 1'b1; data0 = 4'hA;
    tick();
    req0 = 1'b0;
    repeat (3) tick();
    check("pre_reset_so_valid", 32'(so_valid), 1);
    reset = 1'b0;
    #1;
    check("mid_reset_outputs", 32'({pi, gnt0, gnt1, load, so_valid, owner, busy, done}), 0);
    check("mid_reset_so", 32'(so), 0);
    exp_q.delete();
    free_edge    = 0;
    m_last_owner = 1'b1;
    req0 = 1'b1; data0 = 4'h2;
    req1 = 1'b1; data1 = 4'hD;
    tick();
    @(negedge clk);
    reset = 1'b1;
    tick();
    check("post_reset_tie_gnt0", 32'(gnt0), 1);
    req0 = 1'b0;
    req1 = 1'b0;
    wait_idle();
    repeat (SPACING) tick();

    check("scoreboard_empty", exp_q.size(), 0);
    check("no_open_frame", 32'(active), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/piso_tx_arbiter.md
# piso_tx_arbiter

Two-requester round-robin controller for the 4-bit parallel-in/serial-out shift register in the serial transmit path. Accepts a parallel word from either requester via req/gnt, drives the shift register's `pi` and `load` pins, and counts the WIDTH shift cycles. Flags the cycles in which the shift register's `so` carries valid frame bits. Sits between the word producers and the shift register; shares `clk` and `reset` with it.

## Interface
Parameters:
- `WIDTH`, 4: word width; must equal the shift register width.
- `GAP`, 0: idle cycles forced between frames (0..15).

Ports:
- `clk` in 1: rising-edge clock.
- `reset` in 1: asynchronous, active-low reset.
- `req0` in 1: requester 0 request. Held with `data0` until `gnt0`.
- `data0` in WIDTH: requester 0 word.
- `req1` in 1: requester 1 request. Held with `data1` until `gnt1`.
- `data1` in WIDTH: requester 1 word.
- `gnt0` out 1: one-cycle pulse; `data0` was captured at the preceding edge.
- `gnt1` out 1: one-cycle pulse; `data1` was captured at the preceding edge.
- `pi` out WIDTH: registered word to the shift register's `pi`.
- `load` out 1: to the shift register's `load`.
- `so_valid` out 1: shift register `so` holds a frame bit this cycle.
- `owner` out 1: requester that owns the current frame. Meaningful while `busy`=1.
- `busy` out 1: a frame is in progress (LOAD, SHIFT or GAP).
- `done` out 1: one-cycle pulse on the last valid bit of a frame.

## Operation
- FSM states: IDLE, LOAD, SHIFT, GAP. Shift counter `cnt` is clog2(WIDTH)+1 bits wide. Gap counter is 4 bits wide.
- IDLE:
  - `busy`=0.
  - If any `req` is sampled high at an edge: arbitrate, set `pi` <= winner's data, pulse the winner's `gnt`, set `owner` <= winner, go to LOAD.
  - Otherwise stay in IDLE.
- Arbitration: if only one request is high, that requester wins. If both are high, the requester that is not `last_owner` wins. `last_owner` updates on every grant. After reset, `last_owner`=1, so `req0` wins the first tie.
- LOAD: `load`=1 for exactly one cycle. The shift register captures `pi` at the closing edge. Next state is SHIFT with `cnt`=0.
- SHIFT:
  - `so_valid`=1 and `load`=0. The shift register `so` carries `pi[cnt]`, LSB first.
  - `cnt` increments every cycle.
  - When `cnt`=WIDTH-1: `done`=1 that cycle. Next state is GAP if GAP>0, otherwise IDLE.
- GAP: stays GAP cycles with `busy`=1 and `so_valid`=0, then goes to IDLE.
- Requests are ignored (not queued) outside IDLE. A requester that drops `req` before its grant is not served.
- `pi` holds its value until the next grant.
- `load` is 0 in every state except LOAD, so the idle shift register shifts in zeros.

## Timing
- Reset (`reset`=0, asynchronous): the FSM goes to IDLE, `cnt` and the gap counter clear, `last_owner`=1. All outputs go to 0 (`pi`, `load`, `gnt0`, `gnt1`, `so_valid`, `owner`, `busy`, `done`).
- Reset mid-frame aborts the frame immediately, with no `done`. The shift register clears on the same reset.
- Frame cycle numbering, with the request sampled at edge E0:
  - Cycle 1: `gnt`, `load`, `busy` all rise.
  - Cycles 2..WIDTH+1: `so_valid`=1.
  - Cycle WIDTH+1: `done`=1.
  - Cycle WIDTH+2: IDLE when GAP=0.
- Minimum grant-to-grant spacing is WIDTH+2+GAP cycles: 6 for the default parameters.
- The earliest next grant comes from a request sampled at the first IDLE edge.
- `gnt0` and `gnt1` are never high in the same cycle.
- `load` and `so_valid` are never high in the same cycle.
- All outputs are registered or decoded from registered state only. There are no combinational paths from `req` or `data` to any output.

## Test plan
- Reset, then `req0`=1 with `data0`=4'b1011 → `gnt0` and `load` high in cycle 1 with `pi`=1011. `so_valid` high in cycles 2–5 with `so`=1,1,0,1. `done` in cycle 5. `busy` falls in cycle 6.
- `req0` and `req1` held high, `data0`=4'h3, `data1`=4'hC → grants go 0,1,0,1 at 6-cycle spacing. `owner` matches each grant. Serial streams are 1100 and 0011 respectively.
- `req1` alone held high with `req0`=0 → `gnt1` on every frame at 6-cycle spacing. No grant to 0.
- `req1` pulsed for 2 cycles during SHIFT, then dropped → no `gnt1`. IDLE persists after the frame.
- `reset` pulled low on the 3rd SHIFT cycle → all outputs 0 in the same cycle, no `done`. After release, with both requests high, `gnt0` wins.
- GAP=2, `req0` held high → grants every 8 cycles. `busy` stays high through the gap cycles with `so_valid`=0.
